// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: PC-source encodings, reset vector, fetch FSM states.
// Latency: none, declarations and one combinational helper only.
// Backpressure: not applicable.
package pipeline_pkg;

  // Decode's next-PC selector, shared with control_unit
  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_JR     = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_BRANCH = 2'b11
  } pcsrc_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // Fetch FSM: one outstanding instruction-SRAM request at most
  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

  // One fetched instruction with the address it came from
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_pkt_t;

  // Picks the redirect target named by decode's pcsource
  function automatic logic [31:0] redirect_target(
    input logic [1:0]  src,
    input logic [31:0] bpc,
    input logic [31:0] jpc,
    input logic [31:0] jr_target
  );
    logic [31:0] tgt;
    tgt = 32'd0;
    case (src)
      PCSRC_BRANCH: tgt = bpc;
      PCSRC_JUMP:   tgt = jpc;
      PCSRC_JR:     tgt = jr_target;
      default:      tgt = 32'd0;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {inst,pc} holding buffer for a fetch response decode could not take yet.
// Latency: contents visible the cycle after load; output is a plain register.
// Backpressure: none internal; owner loads only when empty and unloads when IF/ID frees.
module if_skid_buf
  import pipeline_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       unload,
  input  fetch_pkt_t load_pkt,
  output logic       vld,
  output fetch_pkt_t pkt
);

  // Capture on load, release on unload; a load in the same cycle wins
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      pkt <= '0;
    end else if (load) begin
      vld <= 1'b1;
      pkt <= load_pkt;
    end else if (unload) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns PC, drives instruction-SRAM req/ack, feeds the IF/ID register.
// Latency: 2 cycles per instruction minimum (addr_ok cycle, then data_ok cycle loads IF/ID).
// Backpressure: id_stall holds IF/ID; one late response parks in a skid buffer (HOLD).
// Build option IF_ADEL_CHECK_EN: misaligned fetch PCs issue no request and deliver an adel nop.
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] jr_target,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_adel
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, issue_pc_q, redir_pc_q;
  logic         redir_vld_q;

  logic         accept, ifid_free, cap, misaligned, addr_fire;
  logic [31:0]  cap_target, next_pc;
  logic         ifid_load;
  fetch_pkt_t   ifid_pkt;
  logic         skid_load, skid_unload, skid_vld;
  fetch_pkt_t   skid_pkt;

  assign accept    = id_valid && !id_stall;
  assign ifid_free = !id_valid || accept;

  // The instruction decode accepts now is a branch/jump; fetch_pc is its delay slot
  assign cap        = accept && (pcsource != PCSRC_SEQ);
  assign cap_target = redirect_target(pcsource, bpc, jpc, jr_target);

  // A redirect captured this very cycle bypasses the redir register
  assign next_pc = cap         ? cap_target :
                   redir_vld_q ? redir_pc_q :
                                 fetch_pc_q + 32'd4;

  assign inst_addr = {fetch_pc_q[31:2], 2'b00};

`ifdef IF_ADEL_CHECK_EN
  logic adel_sent_q, id_adel_q;
  logic adel_load, adel_redirect;

  assign misaligned    = (fetch_pc_q[1:0] != 2'b00);
  assign adel_load     = (state_q == FS_REQ) && misaligned && ifid_free && !adel_sent_q;
  assign adel_redirect = (state_q == FS_REQ) && misaligned && (cap || redir_vld_q);
`else
  assign misaligned = 1'b0;
`endif

  // Fetch FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FS_REQ;
    else     state_q <= state_d;
  end

  // Fetch FSM next state, SRAM request and IF/ID / skid steering
  always_comb begin
    state_d     = state_q;
    inst_req    = 1'b0;
    addr_fire   = 1'b0;
    ifid_load   = 1'b0;
    ifid_pkt    = '0;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    case (state_q)
      FS_REQ: begin
        inst_req = !misaligned;
        if (!misaligned && inst_addr_ok) begin
          addr_fire = 1'b1;
          state_d   = FS_WAIT;
        end
`ifdef IF_ADEL_CHECK_EN
        if (adel_load) begin
          ifid_load   = 1'b1;
          ifid_pkt.pc = fetch_pc_q;
        end
`endif
      end
      FS_WAIT: begin
        if (inst_data_ok) begin
          if (ifid_free) begin
            ifid_load = 1'b1;
            ifid_pkt  = '{inst: inst_rdata, pc: issue_pc_q};
            state_d   = FS_REQ;
          end else begin
            skid_load = 1'b1;
            state_d   = FS_HOLD;
          end
        end
      end
      FS_HOLD: begin
        if (ifid_free) begin
          skid_unload = 1'b1;
          ifid_load   = 1'b1;
          ifid_pkt    = skid_pkt;
          state_d     = FS_REQ;
        end
      end
      default: state_d = FS_REQ;
    endcase
  end

  // PC bookkeeping: advance on request accept, remember a redirect until it is used
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      issue_pc_q  <= 32'd0;
      redir_pc_q  <= 32'd0;
      redir_vld_q <= 1'b0;
    end else begin
      if (addr_fire) begin
        fetch_pc_q  <= next_pc;
        issue_pc_q  <= fetch_pc_q;
        redir_vld_q <= 1'b0;
      end
`ifdef IF_ADEL_CHECK_EN
      else if (adel_redirect) begin
        fetch_pc_q  <= next_pc;
        redir_vld_q <= 1'b0;
      end
`endif
      else if (cap) begin
        redir_pc_q  <= cap_target;
        redir_vld_q <= 1'b1;
      end
    end
  end

  // IF/ID register: load when free, otherwise drop valid once decode has taken it
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_inst  <= 32'd0;
      id_pc    <= 32'd0;
    end else if (ifid_load) begin
      id_valid <= 1'b1;
      id_inst  <= ifid_pkt.inst;
      id_pc    <= ifid_pkt.pc;
    end else if (ifid_free) begin
      id_valid <= 1'b0;
    end
  end

`ifdef IF_ADEL_CHECK_EN
  // Report a stuck misaligned fetch once; a redirect re-arms the report
  always_ff @(posedge clk) begin
    if (rst) begin
      adel_sent_q <= 1'b0;
      id_adel_q   <= 1'b0;
    end else begin
      if (adel_redirect)  adel_sent_q <= 1'b0;
      else if (adel_load) adel_sent_q <= 1'b1;
      if (ifid_load) id_adel_q <= adel_load;
    end
  end
  assign id_adel = id_adel_q;
`else
  assign id_adel = 1'b0;
`endif

  if_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .unload   (skid_unload),
    .load_pkt ('{inst: inst_rdata, pc: issue_pc_q}),
    .vld      (skid_vld),
    .pkt      (skid_pkt)
  );

  // Delay slots are never branches, so a redirect never lands on a pending one
  assert property (@(posedge clk) disable iff (rst) !(cap && redir_vld_q));
  // The skid buffer is occupied exactly while the FSM sits in HOLD
  assert property (@(posedge clk) disable iff (rst) skid_vld == (state_q == FS_HOLD));

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc, jr_target;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_inst, id_pc;
  logic        id_adel;

  int nchk = 0;
  int nerr = 0;

  // SRAM model state
  logic        aok_en, dok_en, spur, pend;
  logic [31:0] pend_addr, req_addr;

  typedef struct {
    logic        stall;
    logic        aok;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[20];

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .pcsource     (pcsource),
    .bpc          (bpc),
    .jpc          (jpc),
    .jr_target    (jr_target),
    .id_stall     (id_stall),
    .id_valid     (id_valid),
    .id_inst      (id_inst),
    .id_pc        (id_pc),
    .id_adel      (id_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  function automatic vec_t mk(input logic stall, input logic aok, input logic [1:0] src,
                              input logic [31:0] tgt, input logic req, input logic [31:0] addr,
                              input logic vld, input logic [31:0] pc);
    vec_t v;
    v.stall = stall; v.aok = aok; v.src = src; v.tgt = tgt;
    v.e_req = req; v.e_addr = addr; v.e_vld = vld; v.e_pc = pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h, want %08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  // Called at a negedge: drive SRAM answers, step one clock, land on the next negedge
  task automatic cycle();
    if (rst) begin
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
    end else begin
      inst_addr_ok = inst_req && aok_en && !pend;
      inst_data_ok = (pend && dok_en) || spur;
    end
    inst_rdata = pend ? mem_word(pend_addr) : (spur ? 32'h0BAD_0BAD : 32'h0);
    req_addr   = inst_addr;
    @(posedge clk);
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (inst_data_ok) pend = 1'b0;
      if (inst_addr_ok) begin
        pend      = 1'b1;
        pend_addr = req_addr;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive_redirect(input logic [1:0] src, input logic [31:0] tgt);
    pcsource  = src;
    bpc       = (src == 2'b11) ? tgt : 32'h0BAD_B000;
    jpc       = (src == 2'b10) ? tgt : 32'h0BAD_C000;
    jr_target = (src == 2'b01) ? tgt : 32'h0BAD_D000;
  endtask

  task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
    chk1({tag, ".req"}, inst_req, req);
    if (req) chk({tag, ".addr"}, inst_addr, addr);
  endtask

  task automatic check_id(input string tag, input logic vld, input logic [31:0] pc);
    logic [31:0] wa;
    wa = {pc[31:2], 2'b00};
    chk1({tag, ".vld"}, id_valid, vld);
    if (vld) begin
      chk({tag, ".pc"}, id_pc, pc);
      chk({tag, ".inst"}, id_inst, mem_word(wa));
      chk1({tag, ".adel"}, id_adel, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; id_stall = 1'b0; aok_en = 1'b1; dok_en = 1'b1; spur = 1'b0;
    drive_redirect(2'b00, 32'h0);
    cycle();
    cycle();
    chk1("rst.vld", id_valid, 1'b0);
    chk("rst.inst", id_inst, 32'h0);
    chk("rst.pc", id_pc, 32'h0);
    chk1("rst.adel", id_adel, 1'b0);
    rst = 1'b0;
  endtask

  // Reset, fetch BFC00000, then a jump accepted alongside the delay-slot request
  task automatic jump_from_reset(input logic [31:0] tgt);
    do_reset();
    check_req("jfr0", 1'b1, 32'hBFC0_0000);
    cycle();
    cycle();
    check_req("jfr2", 1'b1, 32'hBFC0_0004);
    check_id("jfr2", 1'b1, 32'hBFC0_0000);
    drive_redirect(2'b10, tgt);
    cycle();
    drive_redirect(2'b00, 32'h0);
    cycle();
  endtask

  initial begin
    pend = 1'b0; pend_addr = 32'h0; req_addr = 32'h0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;

    //            stall aok   src    tgt           req   addr          vld   pc
    vecs[0]  = mk(1'b0, 1'b1, 2'b00, 32'h0,        1'b1, 32'hBFC00000, 1'b0, 32'h0);
    vecs[1]  = mk(1'b0, 1'b1, 2'b00, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
    vecs[2]  = mk(1'b0, 1'b1, 2'b00, 32'h0,        1'b1, 32'hBFC00004, 1'b1, 32'hBFC00000);
    vecs[3]  = mk(1'b0, 1'b1, 2'b00, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
    vecs[4]  = mk(1'b0, 1'b1, 2'b00, 32'h0,        1'b1, 32'hBFC00008, 1'b1, 32'hBFC00004);
    vecs[5]  = mk(1'b0, 1'b1, 2'b00, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
    vecs[6]  = mk(1'b0, 1'b1, 2'b00, 32'h0,        1'b1, 32'hBFC0000C, 1'b1, 32'hBFC00008);
    vecs[7]  = mk(1'b0, 1'b1, 2'b00, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
    vecs[8]  = mk(1'b0, 1'b1, 2'b00, 32'h0,        1'b1, 32'hBFC00010, 1'b1, 32'hBFC0000C);
    vecs[9]  = mk(1'b0, 1'b1, 2'b00, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
    // beq accepted while the delay-slot request is held off: redirect is stored
    vecs[10] = mk(1'b0, 1'b0, 2'b11, 32'hBFC00100, 1'b1, 32'hBFC00014, 1'b1, 32'hBFC00010);
    vecs[11] = mk(1'b0, 1'b1, 2'b00, 32'h0,        1'b1, 32'hBFC00014, 1'b0, 32'h0);
    vecs[12] = mk(1'b0, 1'b1, 2'b00, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
    vecs[13] = mk(1'b0, 1'b1, 2'b00, 32'h0,        1'b1, 32'hBFC00100, 1'b1, 32'hBFC00014);
    vecs[14] = mk(1'b0, 1'b1, 2'b00, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
    // jr accepted in the delay-slot addr_ok cycle: bypass path
    vecs[15] = mk(1'b0, 1'b1, 2'b01, 32'h80001230, 1'b1, 32'hBFC00104, 1'b1, 32'hBFC00100);
    vecs[16] = mk(1'b0, 1'b1, 2'b00, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
    vecs[17] = mk(1'b0, 1'b1, 2'b00, 32'h0,        1'b1, 32'h80001230, 1'b1, 32'hBFC00104);
    vecs[18] = mk(1'b0, 1'b1, 2'b00, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
    vecs[19] = mk(1'b1, 1'b1, 2'b00, 32'h0,        1'b1, 32'h80001234, 1'b1, 32'h80001230);

    do_reset();

    for (int i = 0; i < 20; i++) begin
      id_stall = vecs[i].stall;
      aok_en   = vecs[i].aok;
      drive_redirect(vecs[i].src, vecs[i].tgt);
      check_req($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr);
      check_id($sformatf("v%0d", i), vecs[i].e_vld, vecs[i].e_pc);
      cycle();
    end
    drive_redirect(2'b00, 32'h0);
    aok_en = 1'b1;

    // Decode stalled while the next response returns: it parks in HOLD
    for (int k = 1; k <= 4; k++) begin
      id_stall = 1'b1;
      check_req($sformatf("hold%0d", k), 1'b0, 32'h0);
      check_id($sformatf("hold%0d", k), 1'b1, 32'h80001230);
      cycle();
    end
    id_stall = 1'b0;
    check_req("release", 1'b0, 32'h0);
    check_id("release", 1'b1, 32'h80001230);
    cycle();
    check_req("unhold", 1'b1, 32'h80001238);
    check_id("unhold", 1'b1, 32'h80001234);
    spur = 1'b1;                           // stray data_ok while in REQ
    cycle();
    spur = 1'b0;
    check_req("spur", 1'b0, 32'h0);
    check_id("spur", 1'b0, 32'h0);
    cycle();
    check_req("after", 1'b1, 32'h8000123C);
    check_id("after", 1'b1, 32'h80001238);

    // Redirect captured during WAIT, then reset before it is used
    id_stall = 1'b1;
    cycle();
    id_stall = 1'b0;
    dok_en   = 1'b0;
    drive_redirect(2'b10, 32'h1234_5678);
    check_req("wcap", 1'b0, 32'h0);
    check_id("wcap", 1'b1, 32'h80001238);
    cycle();
    drive_redirect(2'b00, 32'h0);
    check_id("wpend", 1'b0, 32'h0);
    rst = 1'b1;
    cycle();
    rst    = 1'b0;
    dok_en = 1'b1;
    check_req("mrst0", 1'b1, 32'hBFC0_0000);
    check_id("mrst0", 1'b0, 32'h0);
    chk1("mrst0.adel", id_adel, 1'b0);
    cycle();
    check_id("mrst1", 1'b0, 32'h0);
    cycle();
    check_req("mrst2", 1'b1, 32'hBFC0_0004);
    check_id("mrst2", 1'b1, 32'hBFC0_0000);

    // PC wraps past the top of the address space
    jump_from_reset(32'hFFFF_FFFC);
    check_req("wrap0", 1'b1, 32'hFFFF_FFFC);
    check_id("wrap0", 1'b1, 32'hBFC0_0004);
    cycle();
    cycle();
    check_req("wrap1", 1'b1, 32'h0000_0000);
    check_id("wrap1", 1'b1, 32'hFFFF_FFFC);

    // Jump to a misaligned target
    jump_from_reset(32'h8000_0002);
`ifdef IF_ADEL_CHECK_EN
    check_req("adel0", 1'b0, 32'h0);
    check_id("adel0", 1'b1, 32'hBFC0_0004);
    cycle();
    chk1("adel1.req", inst_req, 1'b0);
    chk1("adel1.vld", id_valid, 1'b1);
    chk("adel1.pc", id_pc, 32'h8000_0002);
    chk("adel1.inst", id_inst, 32'h0);
    chk1("adel1.adel", id_adel, 1'b1);
    cycle();
    check_req("adel2", 1'b0, 32'h0);
    chk1("adel2.vld", id_valid, 1'b0);
    cycle();
    cycle();
    check_req("adel4", 1'b0, 32'h0);
    chk1("adel4.vld", id_valid, 1'b0);
`else
    check_req("mis0", 1'b1, 32'h8000_0000);
    check_id("mis0", 1'b1, 32'hBFC0_0004);
    cycle();
    cycle();
    check_req("mis1", 1'b1, 32'h8000_0004);
    chk1("mis1.vld", id_valid, 1'b1);
    chk("mis1.pc", id_pc, 32'h8000_0002);
    chk("mis1.inst", id_inst, 32'h7FFF_FFFF);
    chk1("mis1.adel", id_adel, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline; sits directly upstream of `control_unit`. It owns the PC register and drives the instruction-SRAM request/response handshake. It holds the IF/ID pipeline register that supplies `inst`/`pc` to decode. It consumes decode's `pcsource`/`bpc`/`jpc` plus the forwarded `rs` value to redirect fetch after the branch delay slot.

## Interface
- `RESET_PC`, 32'hBFC0_0000: first fetch address after reset.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset, synchronous, active-high.
- `inst_req`  out  1  request valid to instruction SRAM.
- `inst_addr`  out  32  request address (word-aligned).
- `inst_addr_ok`  in  1  request accepted this cycle.
- `inst_data_ok`  in  1  read data valid this cycle.
- `inst_rdata`  in  32  read data.
- `pcsource`  in  2  from decode: 11 branch-taken, 10 j/jal, 01 jr, 00 sequential.
- `bpc`  in  32  branch target from decode.
- `jpc`  in  32  jump target from decode.
- `jr_target`  in  32  forwarded rs value for jr.
- `id_stall`  in  1  decode cannot accept a new instruction.
- `id_valid`  out  1  IF/ID register holds a valid instruction.
- `id_inst`  out  32  instruction to decode (`inst`).
- `id_pc`  out  32  its PC (`pc`).
- `id_adel`  out  1  fetch address error flag for `id_inst`.

## Operation
- One outstanding request maximum. FSM states:
  - REQ: `inst_req`=1, `inst_addr`=fetch_pc. Transitions to WAIT on `inst_addr_ok`.
  - WAIT: `inst_req`=0, waits for `inst_data_ok`.
  - HOLD: response buffered; decode stalled.
- Accept rule: decode takes IF/ID this cycle when `id_valid && !id_stall`. IF/ID is free when `!id_valid` or accepted.
- REQ→WAIT on `inst_addr_ok`: fetch_pc ← next_pc and issue_pc ← fetch_pc.
- WAIT on `inst_data_ok`:
  - IF/ID free: IF/ID ← {rdata, issue_pc}, `id_valid`←1, →REQ.
  - Otherwise: skid ← {rdata, issue_pc}, →HOLD.
- HOLD with IF/ID free: IF/ID ← skid, →REQ.
- IF/ID free with no new data loaded: `id_valid`←0.
- next_pc = pending redirect target if present, else fetch_pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0).
- Redirect capture:
  - On accept with `pcsource`≠00: target = 11:`bpc`, 10:`jpc`, 01:`jr_target`.
  - Target is stored in redir register, redir_valid←1.
  - At that moment fetch_pc is the delay-slot address. The delay slot is always fetched and delivered normally.
  - The redirect applies to the following address.
- Bypass: if capture and `inst_addr_ok` coincide, next_pc uses the new target directly; redir_valid stays 0.
- redir_valid clears when consumed by `inst_addr_ok`.
- A second redirect while one is pending overwrites it. Cannot legally occur, since the delay slot is never a branch. Verification asserts absence.

## Timing
- Reset values:
  - fetch_pc=`RESET_PC`, state=REQ, `id_valid`=0, `id_inst`=0, `id_pc`=0, `id_adel`=0, redir_valid=0.
  - `inst_req`=1 in the first cycle after reset deasserts.
- Minimum latency:
  - `inst_addr_ok` and `inst_data_ok` each in the cycle after the previous event.
  - Result: one instruction per 2 cycles, IF/ID loaded at the edge ending the `data_ok` cycle.
- `inst_addr` stable while `inst_req`=1 and `!inst_addr_ok`.
- `id_inst`/`id_pc` stable while `id_valid && id_stall`.
- `rst` mid-transaction discards WAIT/HOLD contents and any redirect. The SRAM side shares `rst`, so no stale `data_ok` follows.
- `inst_data_ok` outside WAIT is ignored.

## Configuration
- `IF_ADEL_CHECK_EN` defined: in REQ, if fetch_pc[1:0]≠0, no request is issued (`inst_req`=0).
  - When IF/ID is free, load `id_inst`=0 (nop), `id_pc`=fetch_pc, `id_adel`=1.
  - Fetch then stalls in REQ until a redirect or `rst`. Redirect applies as next fetch_pc.
- Undefined: `inst_addr` = {fetch_pc[31:2],2'b00} and `id_adel` tied 0.

## Structure
- Shared `pipeline_pkg`:
  - PCSRC_SEQ/JR/JUMP/BRANCH encodings, shared with `control_unit`.
  - `RESET_PC` default.
  - Fetch FSM state enum.
- One sub-module: `if_skid_buf` (1-entry {inst,pc} buffer with load/unload/valid).

## Test plan
- Reset, SRAM answers `addr_ok`/`data_ok` next cycle, `id_stall`=0 → addresses BFC00000, BFC00004, BFC00008; `id_pc` follows with `id_valid` every 2nd cycle.
- beq at BFC00010 delivered, `pcsource`=11, `bpc`=BFC00100 → delay slot BFC00014 delivered, next `inst_addr`=BFC00100.
- jr with `jr_target`=80001230 accepted in the same cycle as delay-slot `inst_addr_ok` → next `inst_addr`=80001230 (bypass).
- `id_stall`=1 for 5 cycles while `data_ok` returns → FSM in HOLD, `id_inst` unchanged. After release, buffered instruction appears, no loss or duplication.
- `rst` asserted in WAIT with pending redirect → next `inst_addr`=BFC00000, `id_valid`=0.
- With `IF_ADEL_CHECK_EN`, `jpc`=80000002 → `inst_req` stays 0, `id_adel`=1, `id_pc`=80000002, `id_inst`=0.
